multi_strobe_sync: RTL and testbench



---
 rtl/multi_strobe_sync_pkg.sv | 18 +
 rtl/strobe_sync_ch.sv | 125 ++++++++++++
 rtl/multi_strobe_sync.sv | 53 +++++
 tb/tb_multi_strobe_sync.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_strobe_sync_pkg.sv
// Shared definitions for the multi-channel strobe synchroniser.
//   EDGE_* : per-channel edge-select codes carried on the mode bus
//   clog2  : counter width helper, never returns less than 1
package multi_strobe_sync_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/strobe_sync_ch.sv
// One strobe channel: synchroniser -> glitch filter -> edge qualifier ->
// fixed-width pulse generator, plus sticky overrun flag and event counter.
// Ports:
//   clk_sys, rst : clock, synchronous active-high reset
//   strb_i       : asynchronous strobe input
//   en           : channel enable (gates pulse, count and overrun)
//   mode         : edge select (EDGE_NONE/RISE/FALL/BOTH)
//   clr          : clears overrun flag and event counter
//   pulse_o      : registered output pulse, polarity set by ACTIVE_LOW
//   overrun_o    : sticky, qualified edge seen while a pulse was running
//   evt_cnt_o    : wrapping count of enabled qualified edges
module strobe_sync_ch
  import multi_strobe_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2,
  parameter int PULSE_W     = 1,
  parameter bit IDLE_LEVEL  = 1'b1,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             strb_i,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             pulse_o,
  output logic             overrun_o,
  output logic [CNT_W-1:0] evt_cnt_o
);

  localparam int FCW = clog2(FILT_LEN + 1);
  localparam int PCW = clog2(PULSE_W + 1);
  // The filter accepts the new level on the cycle its counter would reach FILT_LEN.
  localparam logic [FCW-1:0] FILT_LAST  = FCW'(FILT_LEN - 1);
  localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_W);
  localparam logic           PULSE_ON   = ~ACTIVE_LOW;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   f_q, f_d;
  logic [FCW-1:0]         filt_cnt_q, filt_cnt_d;
  logic [PCW-1:0]         pulse_cnt_q, pulse_cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   ovr_q, ovr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic s;
  logic toggle;
  logic qual;
  logic fire;
  logic busy;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], strb_i};
    s          = sync_q[SYNC_STAGES-1];
    f_d        = f_q;
    filt_cnt_d = '0;
    toggle     = 1'b0;
    // Any return of s to f drops the counter, discarding a short excursion.
    if (s != f_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        f_d    = ~f_q;
        toggle = 1'b1;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end

    // Qualification looks at the direction of the toggle (new level of f),
    // so a mode change alone can never produce an edge.
    case (mode)
      EDGE_NONE: qual = 1'b0;
      EDGE_RISE: qual = toggle & f_d;
      EDGE_FALL: qual = toggle & ~f_d;
      EDGE_BOTH: qual = toggle;
      default:   qual = 1'b0;
    endcase

    fire = qual & en;
    busy = (pulse_cnt_q != '0);

    // No retrigger: an edge during a running pulse only raises overrun.
    if (!en)               pulse_cnt_d = '0;
    else if (fire && !busy) pulse_cnt_d = PULSE_LOAD;
    else if (busy)         pulse_cnt_d = pulse_cnt_q - 1'b1;
    else                   pulse_cnt_d = '0;

    // Gating with en makes a mid-pulse disable take effect on the next edge.
    pulse_d = (en && busy) ? PULSE_ON : ~PULSE_ON;

    if (clr) begin
      ovr_d = 1'b0;
      cnt_d = '0;
    end else begin
      ovr_d = ovr_q | (fire & busy);
      cnt_d = fire ? cnt_q + 1'b1 : cnt_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync_q      <= {SYNC_STAGES{IDLE_LEVEL}};
      f_q         <= IDLE_LEVEL;
      filt_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      pulse_q     <= ~PULSE_ON;
      ovr_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      f_q         <= f_d;
      filt_cnt_q  <= filt_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      pulse_q     <= pulse_d;
      ovr_q       <= ovr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pulse_o   = pulse_q;
  assign overrun_o = ovr_q;
  assign evt_cnt_o = cnt_q;

endmodule

// File: rtl/multi_strobe_sync.sv
// N-channel strobe synchroniser / pulse generator. Each channel is an
// independent strobe_sync_ch; this level only slices the buses.
// Ports:
//   clk_sys, rst : clock, synchronous active-high reset
//   strb_i[N_CH] : asynchronous strobes;  en[N_CH] : per-channel enables
//   mode[2*N_CH] : edge select, channel c at [2c+1:2c]
//   clr          : clears all overrun flags and event counters
//   pulse_o, overrun_o : per-channel outputs
//   evt_cnt_o    : event counters, channel c at [CNT_W*(c+1)-1:CNT_W*c]
module multi_strobe_sync
  import multi_strobe_sync_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2,
  parameter int PULSE_W     = 1,
  parameter bit IDLE_LEVEL  = 1'b1,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic [N_CH-1:0]       strb_i,
  input  logic [N_CH-1:0]       en,
  input  logic [2*N_CH-1:0]     mode,
  input  logic                  clr,
  output logic [N_CH-1:0]       pulse_o,
  output logic [N_CH-1:0]       overrun_o,
  output logic [N_CH*CNT_W-1:0] evt_cnt_o
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    strobe_sync_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN),
      .PULSE_W    (PULSE_W),
      .IDLE_LEVEL (IDLE_LEVEL),
      .ACTIVE_LOW (ACTIVE_LOW),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk_sys  (clk_sys),
      .rst      (rst),
      .strb_i   (strb_i[c]),
      .en       (en[c]),
      .mode     (mode[2*c +: 2]),
      .clr      (clr),
      .pulse_o  (pulse_o[c]),
      .overrun_o(overrun_o[c]),
      .evt_cnt_o(evt_cnt_o[CNT_W*c +: CNT_W])
    );
  end

endmodule

// File: tb/tb_multi_strobe_sync.sv
// Bench for multi_strobe_sync: default instance (a) plus PULSE_W=8/CNT_W=4
// instance (b), both driven by the same inputs and checked every cycle
// against a behavioural model, plus table vectors and directed sequences.
module tb_multi_strobe_sync;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int FILT = 2;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        rst;
  logic [3:0]  strb, en;
  logic [7:0]  mode;
  logic        clr;
  logic [3:0]  a_pulse, a_ovr, b_pulse, b_ovr;
  logic [31:0] a_cnt;
  logic [15:0] b_cnt;

  multi_strobe_sync dut_a (
    .clk_sys(clk_sys), .rst(rst), .strb_i(strb), .en(en), .mode(mode), .clr(clr),
    .pulse_o(a_pulse), .overrun_o(a_ovr), .evt_cnt_o(a_cnt)
  );

  multi_strobe_sync #(.PULSE_W(8), .CNT_W(4)) dut_b (
    .clk_sys(clk_sys), .rst(rst), .strb_i(strb), .en(en), .mode(mode), .clr(clr),
    .pulse_o(b_pulse), .overrun_o(b_ovr), .evt_cnt_o(b_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance k and channel c: delayed strobe samples, accepted level,
  // length of the current disagreement run, remaining pulse cycles, count.
  int pw[2] = '{1, 8};
  int cw[2] = '{8, 4};
  int m_sync[2][N][SYNC];
  int m_f[2][N], m_run[2][N], m_rem[2][N], m_cnt[2][N], m_ov[2][N], m_act[2][N];

  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < N; c++) begin
        int s;
        bit tog, qual, e;
        logic [1:0] md;
        md = mode[2*c +: 2];
        e  = en[c];
        if (rst) begin
          for (int i = 0; i < SYNC; i++) m_sync[k][c][i] = 1;
          m_f[k][c] = 1; m_run[k][c] = 0; m_rem[k][c] = 0;
          m_cnt[k][c] = 0; m_ov[k][c] = 0; m_act[k][c] = 0;
        end else begin
          s = m_sync[k][c][SYNC-1];
          for (int i = SYNC-1; i > 0; i--) m_sync[k][c][i] = m_sync[k][c][i-1];
          m_sync[k][c][0] = int'(strb[c]);
          tog = 0;
          if (s == m_f[k][c]) m_run[k][c] = 0;
          else begin
            m_run[k][c]++;
            if (m_run[k][c] == FILT) begin
              m_f[k][c] = 1 - m_f[k][c];
              m_run[k][c] = 0;
              tog = 1;
            end
          end
          qual = tog && ((m_f[k][c] == 1 && md[0]) || (m_f[k][c] == 0 && md[1]));
          m_act[k][c] = e && (m_rem[k][c] > 0);
          if (clr) begin
            m_cnt[k][c] = 0; m_ov[k][c] = 0;
          end else if (e && qual) begin
            m_cnt[k][c] = (m_cnt[k][c] + 1) % (1 << cw[k]);
            if (m_rem[k][c] > 0) m_ov[k][c] = 1;
          end
          if (!e) m_rem[k][c] = 0;
          else if (qual && m_rem[k][c] == 0) m_rem[k][c] = pw[k];
          else if (m_rem[k][c] > 0) m_rem[k][c]--;
        end
      end
    end
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < N; c++) begin
        int ap, ao, ac;
        ap = (k == 0) ? int'(a_pulse[c]) : int'(b_pulse[c]);
        ao = (k == 0) ? int'(a_ovr[c])   : int'(b_ovr[c]);
        ac = (k == 0) ? int'(a_cnt[8*c +: 8]) : int'(b_cnt[4*c +: 4]);
        check($sformatf("model_pulse k%0d c%0d", k, c), ap, m_act[k][c] ? 0 : 1);
        check($sformatf("model_ovr k%0d c%0d", k, c), ao, m_ov[k][c]);
        check($sformatf("model_cnt k%0d c%0d", k, c), ac, m_cnt[k][c]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic strb0;
    int   exp_pulse;
    int   exp_cnt;   // -1: not checked on this row
  } vec_t;
  vec_t vecs[$];

  function automatic void add_vec(input logic s, input int p, input int c);
    vec_t v;
    v.strb0 = s; v.exp_pulse = p; v.exp_cnt = c;
    vecs.push_back(v);
  endfunction

  // ---------------- test ----------------
  initial begin
    int act_n, starts;
    int st[N];
    logic prev;
    int hold[N];

    rst = 1'b1; strb = 4'hF; en = 4'hF; clr = 1'b0;
    mode = 8'b11_00_01_10;  // ch0 fall, ch1 rise, ch2 none, ch3 both
    steps(3);
    check("reset_pulse_a", int'(a_pulse), 15);
    check("reset_ovr_a",   int'(a_ovr), 0);
    check("reset_cnt_a",   int'(a_cnt), 0);
    check("reset_pulse_b", int'(b_pulse), 15);
    rst = 1'b0;
    steps(5);
    check("idle_no_pulse", int'(a_pulse), 15);

    // Fall held: pulse at edge 5; rise ignored; 1-cycle glitch; 2-cycle low.
    for (int i = 1; i <= 12; i++) add_vec(1'b0, (i == 5) ? 0 : 1, (i >= 6) ? 1 : ((i <= 3) ? 0 : -1));
    for (int i = 1; i <= 12; i++) add_vec(1'b1, 1, 1);
    add_vec(1'b0, 1, 1);
    for (int i = 1; i <= 10; i++) add_vec(1'b1, 1, 1);
    for (int j = 1; j <= 12; j++) add_vec((j <= 2) ? 1'b0 : 1'b1, (j == 5) ? 0 : 1, (j >= 6) ? 2 : ((j <= 3) ? 1 : -1));
    for (int i = 0; i < vecs.size(); i++) begin
      strb[0] = vecs[i].strb0;
      step();
      check($sformatf("tbl_pulse row%0d", i), int'(a_pulse[0]), vecs[i].exp_pulse);
      if (vecs[i].exp_cnt >= 0) check($sformatf("tbl_cnt row%0d", i), int'(a_cnt[7:0]), vecs[i].exp_cnt);
    end
    check("tbl_no_overrun", int'(a_ovr[0]), 0);

    // Overrun on instance b: fall then rise 3 cycles later, mode both.
    mode[1:0] = 2'b11;
    clr = 1'b1; step(); clr = 1'b0; step();
    strb[0] = 1'b0;
    act_n = 0; starts = 0; prev = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      if (i == 4) strb[0] = 1'b1;
      step();
      if (b_pulse[0] == 1'b0) act_n++;
      if (b_pulse[0] == 1'b0 && prev == 1'b1) starts++;
      prev = b_pulse[0];
    end
    check("ovr_pulse_width", act_n, 8);
    check("ovr_single_pulse", starts, 1);
    check("ovr_flag", int'(b_ovr[0]), 1);
    check("ovr_cnt", int'(b_cnt[3:0]), 2);
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_ovr", int'(b_ovr[0]), 0);
    check("clr_cnt", int'(b_cnt[3:0]), 0);

    // Enable gating on instance b.
    strb[0] = 1'b0;
    steps(6);
    check("en_pulse_running", int'(b_pulse[0]), 0);
    en[0] = 1'b0;
    step();
    check("en_drop_ends_pulse", int'(b_pulse[0]), 1);
    for (int i = 0; i < 4; i++) begin
      strb[0] = ~strb[0];
      steps(6);
    end
    steps(6);
    check("en_off_cnt", int'(b_cnt[3:0]), 1);
    check("en_off_ovr", int'(b_ovr[0]), 0);
    en[0] = 1'b1;
    act_n = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (b_pulse[0] == 1'b0) act_n++;
    end
    check("en_raise_no_pulse", act_n, 0);
    check("en_raise_cnt", int'(b_cnt[3:0]), 1);

    // Counter wrap and reset mid-pulse.
    strb[0] = 1'b1; rst = 1'b1; steps(2); rst = 1'b0; steps(3);
    for (int i = 0; i < 17; i++) begin
      strb[0] = ~strb[0];
      steps(10);
    end
    check("wrap_cnt_b", int'(b_cnt[3:0]), 1);
    check("wrap_cnt_a", int'(a_cnt[7:0]), 17);
    strb[0] = 1'b1;
    steps(6);
    check("rst_pre_pulse", int'(b_pulse[0]), 0);
    rst = 1'b1; step();
    check("rst_mid_pulse", int'(b_pulse[0]), 1);
    check("rst_mid_ovr", int'(b_ovr[0]), 0);
    check("rst_mid_cnt", int'(b_cnt[3:0]), 0);
    rst = 1'b0;
    act_n = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (b_pulse[0] == 1'b0 || a_pulse[0] == 1'b0) act_n++;
    end
    check("rst_release_no_pulse", act_n, 0);

    // Multi-channel independence on instance a.
    mode = 8'b11_00_01_10; strb = 4'hF; en = 4'hF;
    steps(10);
    clr = 1'b1; step(); clr = 1'b0; step();
    for (int c = 0; c < N; c++) st[c] = 0;
    for (int r = 0; r < 2; r++) begin
      for (int h = 0; h < 2; h++) begin
        strb = (h == 0) ? 4'h0 : 4'hF;
        for (int i = 0; i < 10; i++) begin
          step();
          for (int c = 0; c < N; c++) if (a_pulse[c] == 1'b0) st[c]++;
        end
      end
    end
    check("ind_pulses_ch0", st[0], 2);
    check("ind_pulses_ch1", st[1], 2);
    check("ind_pulses_ch2", st[2], 0);
    check("ind_pulses_ch3", st[3], 4);
    check("ind_cnt_ch0", int'(a_cnt[7:0]), 2);
    check("ind_cnt_ch1", int'(a_cnt[15:8]), 2);
    check("ind_cnt_ch2", int'(a_cnt[23:16]), 0);
    check("ind_cnt_ch3", int'(a_cnt[31:24]), 4);

    // Randomised run, checked every cycle by the model.
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          strb[c] = 1'($urandom_range(0, 1));
          hold[c] = $urandom_range(1, 8);
        end
        hold[c]--;
        if ($urandom_range(0, 99) < 3) mode[2*c +: 2] = 2'($urandom_range(0, 3));
        en[c] = ($urandom_range(0, 19) != 0);
      end
      clr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; clr = 1'b0;
    steps(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
